// File: rtl/prf_pkg.sv
// prf_pkg: shared types and helper constants for the LWR-PRF evaluation
// controller. The constants below describe the default build
// (N=2048, P=32); modules derive their own values from their parameters
// through prf_log2() so that other sizes stay consistent.
package prf_pkg;

  // Evaluation phases of the controller
  typedef enum logic [1:0] {
    PRF_IDLE  = 2'd0,
    PRF_ACCUM = 2'd1,
    PRF_ROUND = 2'd2,
    PRF_OUT   = 2'd3
  } prf_eval_state_t;

  localparam int PRF_N_DEFAULT = 2048;
  localparam int PRF_P_DEFAULT = 32;

  localparam int LOG2_N = $clog2(PRF_N_DEFAULT);
  localparam int LOG2_P = $clog2(PRF_P_DEFAULT);
  localparam int SHIFT  = LOG2_N - LOG2_P;

  // Base-2 logarithm of a power-of-two size parameter
  function automatic int prf_log2(input int value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/prf_eval_ctrl_rounding.sv
// prf_rounding: LWR rounding of an inner-product accumulator.
// The window above the top log2(N)+1 bits of the accumulator is reduced
// mod 2N; when the mod-2N msb is set the LOG2_P-bit slice below it is
// negated mod P, otherwise it passes through unchanged.
module prf_rounding
  import prf_pkg::*;
#(
  parameter int N         = 2048,
  parameter int P         = 32,
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0]     i_acc,
  output logic [$clog2(P)-1:0]     o_prf
);

  localparam int C_LOG2_N = prf_log2(N);
  localparam int C_LOG2_P = prf_log2(P);

  logic                w_msb;
  logic [C_LOG2_P-1:0] w_r;
  logic                w_unused_bits;

  assign w_msb = i_acc[C_LOG2_N];
  assign w_r   = i_acc[C_LOG2_N-1 -: C_LOG2_P];

  // Bits outside the rounding window carry no information for the output
  assign w_unused_bits = ^i_acc;

  // Negate the slice mod P when the msb of acc mod 2N is set
  always_comb begin
    o_prf = w_r;
    if (w_msb) begin
      o_prf = {C_LOG2_P{1'b0}} - w_r;
    end else begin
      o_prf = w_r;
    end
  end

endmodule

// File: rtl/prf_eval_ctrl.sv
// prf_eval_ctrl: sequencer for one LWR-PRF evaluation.
// Streams N (in_a, in_s) pairs, accumulates their inner product modulo
// 2^ACC_WIDTH, rounds the result through prf_rounding in a single cycle
// and holds it on a valid/ready output port.
// Optional feature: define PRF_ABORT_EN to add the `abort` input, which
// returns a busy controller to IDLE and discards all partial state.
module prf_eval_ctrl
  import prf_pkg::*;
#(
  parameter int N          = 2048,
  parameter int P          = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int ELEM_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_WIDTH-1:0] in_a,
  input  logic [ELEM_WIDTH-1:0] in_s,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(P)-1:0]  prf_out,
  output logic                  busy
`ifdef PRF_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int C_LOG2_N = prf_log2(N);
  localparam int C_LOG2_P = prf_log2(P);

  prf_eval_state_t         r_state;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [C_LOG2_N-1:0]     r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic [C_LOG2_P-1:0]     r_prf;

  logic [2*ELEM_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_acc_next;
  logic                    w_last_beat;
  logic                    w_abort;
  logic [C_LOG2_P-1:0]     w_round;

`ifdef PRF_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Product is truncated (or zero-extended) to the accumulator width: wrap, no saturation
  assign w_prod      = in_a * in_s;
  assign w_acc_next  = r_acc + ACC_WIDTH'(w_prod);
  assign w_last_beat = (r_cnt == {C_LOG2_N{1'b1}});

  prf_rounding #(
    .N        (N),
    .P        (P),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_rounding (
    .i_acc(r_acc),
    .o_prf(w_round)
  );

  // Controller state, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PRF_IDLE;
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_cnt       <= {C_LOG2_N{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_prf       <= {C_LOG2_P{1'b0}};
    end else if (w_abort && (r_state != PRF_IDLE)) begin
      // Abort wins over any beat or output handshake in the same cycle
      r_state     <= PRF_IDLE;
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_cnt       <= {C_LOG2_N{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_prf       <= {C_LOG2_P{1'b0}};
    end else begin
      case (r_state)
        PRF_IDLE: begin
          if (start) begin
            r_state    <= PRF_ACCUM;
            r_acc      <= {ACC_WIDTH{1'b0}};
            r_cnt      <= {C_LOG2_N{1'b0}};
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        PRF_ACCUM: begin
          if (in_valid) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + C_LOG2_N'(1);
            if (w_last_beat) begin
              r_state    <= PRF_ROUND;
              r_in_ready <= 1'b0;
            end
          end
        end
        PRF_ROUND: begin
          r_prf       <= w_round;
          r_out_valid <= 1'b1;
          r_state     <= PRF_OUT;
        end
        PRF_OUT: begin
          // start in the handshake cycle is not looked at: IDLE gets at least one cycle
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= PRF_IDLE;
          end
        end
        default: begin
          r_state     <= PRF_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign prf_out   = r_prf;

endmodule
